// File: rtl/cc_sidedetector.sv
// Registered ball side detector: tracks the ball zone, flags paddle hit/miss on arrival and counts hits.
// Optional macro CC_SIDEDETECT_MISSCOUNT_EN adds a saturating miss counter; otherwise misscount reads 0.
module cc_sidedetector #(
    parameter int SIDEDETECT_DATAWIDTH = 8,
    parameter int SIDEDETECT_LEFT_POS  = 3,
    parameter int SIDEDETECT_RIGHT_POS = 0,
    parameter int SIDEDETECT_CNTWIDTH  = 4
) (
    input  logic                            CC_SIDEDETECT_CLOCK_50,
    input  logic                            CC_SIDEDETECT_RESET_InHigh,
    input  logic                            CC_SIDEDETECT_tick_InHigh,
    input  logic                            CC_SIDEDETECT_clear_InHigh,
    input  logic [SIDEDETECT_DATAWIDTH-1:0] CC_SIDEDETECT_data_InBUS,
    input  logic [SIDEDETECT_DATAWIDTH-1:0] CC_SIDEDETECT_paddle_InBUS,
    output logic                            CC_SIDEDETECT_izquierda_OutLow,
    output logic                            CC_SIDEDETECT_derecha_OutLow,
    output logic                            CC_SIDEDETECT_arrive_OutHigh,
    output logic                            CC_SIDEDETECT_hit_OutHigh,
    output logic                            CC_SIDEDETECT_miss_OutHigh,
    output logic [SIDEDETECT_CNTWIDTH-1:0]  CC_SIDEDETECT_hitcount_OutBUS,
    output logic [SIDEDETECT_CNTWIDTH-1:0]  CC_SIDEDETECT_misscount_OutBUS
);

    typedef enum logic [1:0] {MID, AT_LEFT, AT_RIGHT} state_t;

    localparam logic [SIDEDETECT_DATAWIDTH-1:0] ONE_HOT_BASE = {{(SIDEDETECT_DATAWIDTH-1){1'b0}}, 1'b1};
    localparam logic [SIDEDETECT_DATAWIDTH-1:0] LEFT_MASK    = ONE_HOT_BASE << SIDEDETECT_LEFT_POS;
    localparam logic [SIDEDETECT_DATAWIDTH-1:0] RIGHT_MASK   = ONE_HOT_BASE << SIDEDETECT_RIGHT_POS;

    state_t state;
    state_t next_state;
    logic   arrival;
    logic   overlap;

    // Exact one-hot compare: multi-hot or empty rows fall back to MID.
    always_comb begin
        next_state = MID;
        if (CC_SIDEDETECT_data_InBUS == LEFT_MASK)
            next_state = AT_LEFT;
        else if (CC_SIDEDETECT_data_InBUS == RIGHT_MASK)
            next_state = AT_RIGHT;
        arrival = CC_SIDEDETECT_tick_InHigh && (next_state != MID) && (next_state != state);
        overlap = |(CC_SIDEDETECT_data_InBUS & CC_SIDEDETECT_paddle_InBUS);
    end

    always_ff @(posedge CC_SIDEDETECT_CLOCK_50) begin
        if (CC_SIDEDETECT_RESET_InHigh) begin
            state                          <= MID;
            CC_SIDEDETECT_izquierda_OutLow <= 1'b1;
            CC_SIDEDETECT_derecha_OutLow   <= 1'b1;
            CC_SIDEDETECT_arrive_OutHigh   <= 1'b0;
            CC_SIDEDETECT_hit_OutHigh      <= 1'b0;
            CC_SIDEDETECT_miss_OutHigh     <= 1'b0;
            CC_SIDEDETECT_hitcount_OutBUS  <= '0;
        end else begin
            CC_SIDEDETECT_arrive_OutHigh <= arrival;
            CC_SIDEDETECT_hit_OutHigh    <= arrival && overlap;
            if (CC_SIDEDETECT_tick_InHigh) begin
                state                          <= next_state;
                CC_SIDEDETECT_izquierda_OutLow <= (next_state != AT_LEFT);
                CC_SIDEDETECT_derecha_OutLow   <= (next_state != AT_RIGHT);
            end
            // Clear beats a same-cycle arrival for the counter and sticky miss, not for the pulses.
            if (CC_SIDEDETECT_clear_InHigh) begin
                CC_SIDEDETECT_hitcount_OutBUS <= '0;
                CC_SIDEDETECT_miss_OutHigh    <= 1'b0;
            end else if (arrival) begin
                if (overlap) begin
                    if (CC_SIDEDETECT_hitcount_OutBUS != '1)
                        CC_SIDEDETECT_hitcount_OutBUS <= CC_SIDEDETECT_hitcount_OutBUS + SIDEDETECT_CNTWIDTH'(1);
                end else begin
                    CC_SIDEDETECT_miss_OutHigh <= 1'b1;
                end
            end
        end
    end

`ifdef CC_SIDEDETECT_MISSCOUNT_EN
    always_ff @(posedge CC_SIDEDETECT_CLOCK_50) begin
        if (CC_SIDEDETECT_RESET_InHigh || CC_SIDEDETECT_clear_InHigh)
            CC_SIDEDETECT_misscount_OutBUS <= '0;
        else if (arrival && !overlap && (CC_SIDEDETECT_misscount_OutBUS != '1))
            CC_SIDEDETECT_misscount_OutBUS <= CC_SIDEDETECT_misscount_OutBUS + SIDEDETECT_CNTWIDTH'(1);
    end
`else
    assign CC_SIDEDETECT_misscount_OutBUS = '0;
`endif

endmodule

// File: tb/tb_cc_sidedetector.sv
// Bench for cc_sidedetector: directed vector table, hit saturation sequence and a randomized run against a zone model.
module tb_cc_sidedetector;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       clear;
    logic [7:0] data;
    logic [7:0] paddle;
    logic       izq_n;
    logic       der_n;
    logic       arrive;
    logic       hit;
    logic       miss;
    logic [3:0] hitcount;
    logic [3:0] misscount;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: zone 0=middle, 1=left edge, 2=right edge; counts kept as plain integers.
    int m_zone;
    int m_hc;
    int m_mc;
    bit m_arrive;
    bit m_hit;
    bit m_miss;

    typedef struct {
        bit         r;
        bit         t;
        bit         c;
        logic [7:0] d;
        logic [7:0] p;
        bit         e_izq;
        bit         e_der;
        bit         e_arr;
        bit         e_hit;
        bit         e_miss;
        int         e_hc;
        int         e_mc;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    cc_sidedetector dut (
        .CC_SIDEDETECT_CLOCK_50         (clk),
        .CC_SIDEDETECT_RESET_InHigh     (reset),
        .CC_SIDEDETECT_tick_InHigh      (tick),
        .CC_SIDEDETECT_clear_InHigh     (clear),
        .CC_SIDEDETECT_data_InBUS       (data),
        .CC_SIDEDETECT_paddle_InBUS     (paddle),
        .CC_SIDEDETECT_izquierda_OutLow (izq_n),
        .CC_SIDEDETECT_derecha_OutLow   (der_n),
        .CC_SIDEDETECT_arrive_OutHigh   (arrive),
        .CC_SIDEDETECT_hit_OutHigh      (hit),
        .CC_SIDEDETECT_miss_OutHigh     (miss),
        .CC_SIDEDETECT_hitcount_OutBUS  (hitcount),
        .CC_SIDEDETECT_misscount_OutBUS (misscount)
    );

    function automatic int expMissCount(int with_macro);
`ifdef CC_SIDEDETECT_MISSCOUNT_EN
        return with_macro;
`else
        return 0;
`endif
    endfunction

    function automatic int satInc(int v);
        return (v < 15) ? v + 1 : 15;
    endfunction

    task automatic modelStep(bit r, bit t, bit c, logic [7:0] d, logic [7:0] p);
        int nz;
        if (r) begin
            m_zone = 0; m_hc = 0; m_mc = 0;
            m_arrive = 0; m_hit = 0; m_miss = 0;
        end else begin
            m_arrive = 0;
            m_hit    = 0;
            if (t) begin
                nz = (d == 8'h08) ? 1 : (d == 8'h01) ? 2 : 0;
                if (nz != 0 && nz != m_zone) begin
                    m_arrive = 1;
                    if ((d & p) != 0) begin
                        m_hit = 1;
                        m_hc  = satInc(m_hc);
                    end else begin
                        m_miss = 1;
                        m_mc   = satInc(m_mc);
                    end
                end
                m_zone = nz;
            end
            if (c) begin
                m_hc = 0; m_mc = 0; m_miss = 0;
            end
        end
    endtask

    task automatic applyStimulus(bit r, bit t, bit c, logic [7:0] d, logic [7:0] p);
        reset  = r;
        tick   = t;
        clear  = c;
        data   = d;
        paddle = p;
        @(posedge clk);
        modelStep(r, t, c, d, p);
        #1;
    endtask

    task automatic checkOutput(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkModel(string tag);
        checkOutput({tag, ".izq"},       int'(izq_n),     int'(m_zone != 1));
        checkOutput({tag, ".der"},       int'(der_n),     int'(m_zone != 2));
        checkOutput({tag, ".arrive"},    int'(arrive),    int'(m_arrive));
        checkOutput({tag, ".hit"},       int'(hit),       int'(m_hit));
        checkOutput({tag, ".miss"},      int'(miss),      int'(m_miss));
        checkOutput({tag, ".hitcount"},  int'(hitcount),  m_hc);
        checkOutput({tag, ".misscount"}, int'(misscount), expMissCount(m_mc));
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; clear = 1'b0; data = 8'h00; paddle = 8'h00;
        modelStep(1, 0, 0, 8'h00, 8'h00);

        //            r  t  c  data   paddle izq der arr hit miss hc mc(macro)
        vecs[0]  = '{1, 1, 0, 8'h08, 8'h00, 1,  1,  0,  0,  0,   0, 0};
        vecs[1]  = '{1, 1, 0, 8'h08, 8'h00, 1,  1,  0,  0,  0,   0, 0};
        vecs[2]  = '{0, 1, 0, 8'h08, 8'h00, 0,  1,  1,  0,  1,   0, 1};
        vecs[3]  = '{0, 0, 1, 8'h08, 8'h00, 0,  1,  0,  0,  0,   0, 0};
        vecs[4]  = '{0, 1, 0, 8'h02, 8'h01, 1,  1,  0,  0,  0,   0, 0};
        vecs[5]  = '{0, 1, 0, 8'h01, 8'h01, 1,  0,  1,  1,  0,   1, 0};
        vecs[6]  = '{0, 1, 0, 8'h01, 8'h01, 1,  0,  0,  0,  0,   1, 0};
        vecs[7]  = '{0, 0, 0, 8'h08, 8'h08, 1,  0,  0,  0,  0,   1, 0};
        vecs[8]  = '{0, 0, 0, 8'h01, 8'h00, 1,  0,  0,  0,  0,   1, 0};
        vecs[9]  = '{0, 1, 0, 8'h08, 8'hF0, 0,  1,  1,  0,  1,   1, 1};
        vecs[10] = '{0, 1, 0, 8'h01, 8'h01, 1,  0,  1,  1,  1,   2, 1};
        vecs[11] = '{0, 1, 0, 8'h09, 8'hFF, 1,  1,  0,  0,  1,   2, 1};
        vecs[12] = '{0, 1, 1, 8'h08, 8'h08, 0,  1,  1,  1,  0,   0, 0};
        vecs[13] = '{1, 1, 0, 8'h01, 8'h00, 1,  1,  0,  0,  0,   0, 0};
        vecs[14] = '{0, 0, 0, 8'h01, 8'h00, 1,  1,  0,  0,  0,   0, 0};

        for (int i = 0; i < 15; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].r, vecs[i].t, vecs[i].c, vecs[i].d, vecs[i].p);
            checkOutput({tag, ".izq"},       int'(izq_n),     int'(vecs[i].e_izq));
            checkOutput({tag, ".der"},       int'(der_n),     int'(vecs[i].e_der));
            checkOutput({tag, ".arrive"},    int'(arrive),    int'(vecs[i].e_arr));
            checkOutput({tag, ".hit"},       int'(hit),       int'(vecs[i].e_hit));
            checkOutput({tag, ".miss"},      int'(miss),      int'(vecs[i].e_miss));
            checkOutput({tag, ".hitcount"},  int'(hitcount),  vecs[i].e_hc);
            checkOutput({tag, ".misscount"}, int'(misscount), expMissCount(vecs[i].e_mc));
        end

        // Alternate edges with full paddle: every tick is a hit arrival until the count saturates.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, (i % 2 == 1) ? 8'h01 : 8'h08, 8'hFF);
            checkOutput($sformatf("sat%0d.arrive", i),   int'(arrive),   1);
            checkOutput($sformatf("sat%0d.hitcount", i), int'(hitcount), (i + 1 < 15) ? i + 1 : 15);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 8'h01, 8'hFF);
            checkOutput($sformatf("hold%0d.arrive", i),   int'(arrive),   0);
            checkOutput($sformatf("hold%0d.hitcount", i), int'(hitcount), 15);
        end
        applyStimulus(0, 0, 1, 8'h08, 8'h00);
        checkOutput("clr.hitcount", int'(hitcount), 0);
        checkOutput("clr.miss",     int'(miss),     0);
        checkOutput("clr.der",      int'(der_n),    0);
        checkOutput("clr.izq",      int'(izq_n),    1);
        checkModel("clr");

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 4))
                0:       d = 8'h08;
                1:       d = 8'h01;
                2:       d = 8'h09;
                3:       d = 8'h00;
                default: d = 8'($urandom);
            endcase
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0, d, 8'($urandom));
            checkModel($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
